// File: rtl/systolic_sequencer.sv
// -----------------------------------------------------------------------------
// systolic_sequencer
//   Instruction-driven controller for a ROWS x ROWS systolic matrix-multiply
//   array. After ap_start it fetches instructions one at a time. Each non-zero
//   instruction x is the inner dimension of one multiply. For each multiply
//   the sequencer clears the PE accumulators, streams x+2*(ROWS-1) pre-skewed
//   columns from memA/memB, and writes the ROWS*ROWS results to output memory.
//   A run ends on a zero instruction or after the last instruction-memory
//   entry, and then ap_done pulses for one cycle.
//
// Ports
//   clk             rising-edge clock
//   rst             asynchronous, active-low reset
//   ap_start        start pulse, sampled only while idle
//   ap_done         one-cycle completion pulse
//   inst_rd         instruction memory read enable
//   inst_addr       instruction memory address
//   inst_data       instruction read data, valid one cycle after inst_rd
//   currInstruction latched instruction being executed
//   rd_en           memA/memB read enable, all lanes at column rd_col
//   rd_col          column address, lane data returns one cycle later
//   arr_clr         synchronous clear of all PE accumulators
//   arr_en          array shift/MAC enable, rd_en delayed by one cycle
//   res_idx         PE select for the result readout mux (row*ROWS+col)
//   out_we          output memory write enable
//   out_addr        output memory write address
//   busy            high in every state except IDLE
// -----------------------------------------------------------------------------
module systolic_sequencer #(
  parameter int ROWS       = 4,
  parameter int COL_W      = 8,
  parameter int INST_DEPTH = 8,
  parameter int INST_W     = 4,
  parameter int OADDR_W    = 7,
  localparam int IADDR_W   = $clog2(INST_DEPTH),
  localparam int RES_W     = $clog2(ROWS * ROWS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ap_start,
  output logic               ap_done,
  output logic               inst_rd,
  output logic [IADDR_W-1:0] inst_addr,
  input  logic [INST_W-1:0]  inst_data,
  output logic [INST_W-1:0]  currInstruction,
  output logic               rd_en,
  output logic [COL_W-1:0]   rd_col,
  output logic               arr_clr,
  output logic               arr_en,
  output logic [RES_W-1:0]   res_idx,
  output logic               out_we,
  output logic [OADDR_W-1:0] out_addr,
  output logic               busy
);

  localparam int RR    = ROWS * ROWS;
  localparam int K_W   = $clog2(INST_DEPTH + 1);
  // One counter serves both the column stream and the result readout.
  localparam int CNT_W = (COL_W > RES_W + 1) ? COL_W : RES_W + 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_CLEAR,
    S_STREAM,
    S_FLUSH,
    S_WRITE,
    S_NEXT,
    S_DONE
  } state_t;

  state_t             state, state_nxt;
  logic [K_W-1:0]     k;
  logic [COL_W-1:0]   base;
  logic [CNT_W-1:0]   cnt;
  logic [INST_W-1:0]  curr_inst;
  logic [COL_W-1:0]   seg;
  logic               stream_last;
  logic               write_last;
  logic               k_last;

  // Columns per instruction; computed at column-address width so the column
  // base wraps with rd_col.
  assign seg         = COL_W'(curr_inst) + COL_W'(2 * (ROWS - 1));
  assign stream_last = (COL_W'(cnt) == seg - 1'b1);
  assign write_last  = (cnt == CNT_W'(RR - 1));
  assign k_last      = (k == K_W'(INST_DEPTH - 1));

  assign busy            = (state != S_IDLE);
  assign currInstruction = curr_inst;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // NOTE: every output and next-state value gets a default first, so no path
  // through the case statement can leave a latch behind.
  always_comb begin
    state_nxt = state;
    ap_done   = 1'b0;
    inst_rd   = 1'b0;
    inst_addr = '0;
    rd_en     = 1'b0;
    rd_col    = '0;
    arr_clr   = 1'b0;
    res_idx   = '0;
    out_we    = 1'b0;
    out_addr  = '0;
    case (state)
      S_IDLE: begin
        if (ap_start) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        inst_rd   = 1'b1;
        inst_addr = IADDR_W'(k);
        state_nxt = S_LOAD;
      end
      S_LOAD: begin
        state_nxt = (inst_data == '0) ? S_DONE : S_CLEAR;
      end
      S_CLEAR: begin
        arr_clr   = 1'b1;
        state_nxt = S_STREAM;
      end
      S_STREAM: begin
        rd_en  = 1'b1;
        rd_col = base + COL_W'(cnt);
        if (stream_last) state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        // Data for the last column is in flight; arr_en covers it this cycle.
        state_nxt = S_WRITE;
      end
      S_WRITE: begin
        out_we   = 1'b1;
        res_idx  = RES_W'(cnt);
        out_addr = OADDR_W'(32'(k) * RR + 32'(cnt));
        if (write_last) state_nxt = S_NEXT;
      end
      S_NEXT: begin
        state_nxt = k_last ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        // ap_start seen here is deliberately dropped; a new run starts in IDLE.
        ap_done   = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k         <= '0;
      base      <= '0;
      cnt       <= '0;
      curr_inst <= '0;
      arr_en    <= 1'b0;
    end else begin
      arr_en <= rd_en;
      case (state)
        S_IDLE: begin
          if (ap_start) begin
            k    <= '0;
            base <= '0;
          end
        end
        S_LOAD:   curr_inst <= inst_data;
        S_CLEAR:  cnt <= '0;
        // Reuse the counter for the readout: it restarts at 0 for WRITE.
        S_STREAM: cnt <= stream_last ? '0 : cnt + 1'b1;
        S_WRITE:  cnt <= cnt + 1'b1;
        S_NEXT: begin
          base <= base + seg;
          k    <= k + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
